// File: rtl/pc_redirect_pkg.sv
// Shared definitions for the fetch/redirect unit: reset PC, fetch state
// encoding and the sequential-PC helper.
package pc_redirect_pkg;

    localparam logic [31:0] PC_RESET = 32'h1C00_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } fetch_state_t;

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_redirect.sv
// Single-outstanding instruction fetch with EX-stage branch redirect:
// issues one request, presents the returned word to ID, squashes wrong-path data.
module pc_redirect
    import pc_redirect_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        branch,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        flush
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic         r_discard;
    logic         r_if_valid;
    logic [31:0]  r_if_pc;
    logic [31:0]  r_if_inst;
    logic         w_redirect;

    assign w_redirect = ex_valid & branch;
    assign flush      = w_redirect;

    // NOTE: gated with rst so no request escapes while reset is held, even
    // though the state register only returns to BOOT at the next edge.
    assign imem_req   = (r_state == ST_REQ) & ~rst;
    assign imem_addr  = r_pc;
    assign if_valid   = r_if_valid;
    assign if_pc      = r_if_pc;
    assign if_inst    = r_if_inst;

    // NOTE: all state here uses non-blocking assignments so every branch of
    // the case reads the pre-edge values of r_pc / r_discard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= PC_RESET;
            r_discard  <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_pc    <= 32'd0;
            r_if_inst  <= 32'd0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_REQ;
                end

                ST_REQ: begin
                    if (w_redirect) begin
                        r_pc <= branch_target;
                    end
                    if (imem_gnt) begin
                        r_state   <= ST_WAIT;
                        r_discard <= w_redirect;
                    end
                end

                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (r_discard | w_redirect) begin
                            // Wrong-path word: drop it and refetch.
                            r_discard <= 1'b0;
                            r_state   <= ST_REQ;
                            if (w_redirect) begin
                                r_pc <= branch_target;
                            end
                        end else begin
                            r_if_inst  <= imem_rdata;
                            r_if_pc    <= r_pc;
                            r_pc       <= next_seq_pc(r_pc);
                            r_if_valid <= 1'b1;
                            r_state    <= ST_HOLD;
                        end
                    end else if (w_redirect) begin
                        r_discard <= 1'b1;
                        r_pc      <= branch_target;
                    end
                end

                ST_HOLD: begin
                    // Redirect takes priority over the ID handshake.
                    if (w_redirect) begin
                        r_if_valid <= 1'b0;
                        r_pc       <= branch_target;
                        r_state    <= ST_REQ;
                    end else if (id_ready) begin
                        r_if_valid <= 1'b0;
                        r_state    <= ST_REQ;
                    end
                end

                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule
